// File: rtl/alu_accumulator.sv
// Execute-stage datapath: on each Exec strobe, decodes IR and updates the
// accumulator AR and status Flags; undecodable opcodes pulse ill_op.
`ifndef ZERO
`define ZERO 0
`endif
`ifndef CARRY
`define CARRY 1
`endif
`ifndef NEG
`define NEG 2
`endif
`ifndef OV
`define OV 3
`endif
`ifndef NOP
`define NOP 8'h00
`endif
`ifndef LOAD_X
`define LOAD_X 8'h08
`endif
`ifndef LOAD_I
`define LOAD_I 8'h0C
`endif
`ifndef STORE_X
`define STORE_X 8'h10
`endif
`ifndef STORE_I
`define STORE_I 8'h14
`endif
`ifndef JMP
`define JMP 8'h20
`endif
`ifndef JZ
`define JZ 8'h21
`endif
`ifndef JC
`define JC 8'h22
`endif
`ifndef JN
`define JN 8'h23
`endif
`ifndef JV
`define JV 8'h24
`endif

module alu_accumulator #(
    parameter int DATA_WIDTH = 8,
    parameter int INST_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  Exec,
    input  logic [INST_WIDTH-1:0] IR,
    input  logic [DATA_WIDTH-1:0] IBR,
    input  logic [DATA_WIDTH-1:0] MBR,
    output logic [DATA_WIDTH-1:0] AR,
    output logic [3:0]            Flags,
    output logic                  ill_op
);

    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] ar_q, ar_d;
    logic [3:0]            flags_q, flags_d;
    logic                  ill_q, ill_d;

    logic [DATA_WIDTH-1:0] op, op_eff, res;
    logic [DATA_WIDTH:0]   sum, cin_ext;
    logic                  no_effect;

    assign op = IR[2] ? IBR : MBR;
    // Carry-in only for the addc/subc forms.
    assign cin_ext = {{DATA_WIDTH{1'b0}}, IR[1] & flags_q[`CARRY]};
    // Subtraction overflows like an add of the inverted operand.
    assign op_eff = IR[0] ? ~op : op;

    assign no_effect = (IR == `STORE_X) || (IR == `STORE_I) || (IR == `JMP) ||
                       (IR == `JZ) || (IR == `JC) || (IR == `JN) ||
                       (IR == `JV) || (IR == `NOP);

    always_comb begin
        ar_d    = ar_q;
        flags_d = flags_q;
        ill_d   = 1'b0;
        sum     = '0;
        res     = '0;
        if (Exec) begin
            if (IR[7:3] == 5'b01000) begin
                if (IR[0])
                    sum = {1'b0, ar_q} - {1'b0, op} - cin_ext;
                else
                    sum = {1'b0, ar_q} + {1'b0, op} + cin_ext;
                res              = sum[DATA_WIDTH-1:0];
                ar_d             = res;
                flags_d[`CARRY]  = sum[DATA_WIDTH];
                flags_d[`OV]     = (ar_q[MSB] == op_eff[MSB]) && (res[MSB] != ar_q[MSB]);
                flags_d[`ZERO]   = (res == '0);
                flags_d[`NEG]    = res[MSB];
            end else if (IR[7:3] == 5'b10000) begin
                case (IR[1:0])
                    2'b00:   res = ~(ar_q | op);
                    2'b01:   res = ~(ar_q & op);
                    2'b10:   res = ar_q ^ op;
                    default: res = ~(ar_q ^ op);
                endcase
                ar_d           = res;
                flags_d[`OV]   = 1'b0;
                flags_d[`ZERO] = (res == '0);
                flags_d[`NEG]  = res[MSB];
            end else if (IR == `LOAD_X || IR == `LOAD_I) begin
                res            = (IR == `LOAD_I) ? IBR : MBR;
                ar_d           = res;
                flags_d[`ZERO] = (res == '0);
                flags_d[`NEG]  = res[MSB];
            end else if (!no_effect) begin
                ill_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            ar_q    <= '0;
            flags_q <= 4'b0000;
            ill_q   <= 1'b0;
        end else begin
            ar_q    <= ar_d;
            flags_q <= flags_d;
            ill_q   <= ill_d;
        end
    end

    assign AR     = ar_q;
    assign Flags  = flags_q;
    assign ill_op = ill_q;

endmodule

// File: doc/alu_accumulator.md
# alu_accumulator

Execute-stage datapath of the 8-bit microcontroller, directly downstream of the instruction-cycle FSM. On each one-cycle `Exec` pulse it decodes `IR`, selects the second operand (`MBR` for memory-operand forms, `IBR` for immediate forms), and updates the accumulator `AR` and the status `Flags`. Both registers feed back to the instruction-cycle block: `AR` for stores and `Flags` for conditional jumps.

## Interface
- `DATA_WIDTH`, 8, width of `AR`, `MBR`, `IBR` and all arithmetic.
- `INST_WIDTH`, 8, width of `IR`. Opcode decode below assumes 8.
- `clk`  in  1  clock.
- `arst`  in  1  reset; synchronous, active-high.
- `Exec`  in  1  one-cycle strobe; `IR`, `IBR` and `MBR` are valid in the same cycle.
- `IR`  in  INST_WIDTH  instruction register.
- `IBR`  in  DATA_WIDTH  immediate operand.
- `MBR`  in  DATA_WIDTH  memory operand.
- `AR`  out  DATA_WIDTH  accumulator, registered.
- `Flags`  out  4  status, registered. Bit positions are given by `` `ZERO ``, `` `CARRY ``, `` `NEG `` and `` `OV `` from defines.v.
- `ill_op`  out  1  one-cycle pulse on an undecodable opcode, registered.

## Operation
- Operand select:
  - `IR[2]`=0 selects `MBR`; `IR[2]`=1 selects `IBR`.
  - `` `LOAD_X `` uses `MBR`; `` `LOAD_I `` uses `IBR`.
- Arithmetic group, `IR[7:3]`=5'b01000, `ss`=`IR[1:0]`:
  - 00 add: {C,R}=AR+op.
  - 01 sub: R=AR-op; C=1 iff AR<op (borrow).
  - 10 addc: {C,R}=AR+op+C.
  - 11 subc: R=AR-op-C; C=borrow.
  - Sums are computed at DATA_WIDTH+1 bits; C is bit DATA_WIDTH.
  - OV is the signed two's-complement overflow of the operation, including the carry-in.
- Logic group, `IR[7:3]`=5'b10000, `ss`: 00 nor, 01 nand, 10 xor, 11 xnor. C is unchanged; OV is cleared.
- Load: `` `LOAD_X ``/`` `LOAD_I `` set AR=op. Z and N are updated; C and OV are unchanged.
- Z=(R==0) and N=R[DATA_WIDTH-1] are updated by every arithmetic, logic and load instruction.
- No-effect opcodes leave AR, Flags and `ill_op` unchanged: `` `STORE_X ``, `` `STORE_I ``, `` `JMP ``, `` `JZ ``, `` `JC ``, `` `JN ``, `` `JV ``, and `` `NOP `` if defined.
- Any other opcode with `Exec`=1 leaves AR and Flags unchanged and pulses `ill_op` for one cycle.
- With `Exec`=0, all registers hold regardless of `IR`/`IBR`/`MBR` activity.
- Internal state is AR, Flags and `ill_op` only. No multi-cycle operations.

## Timing
- Reset: at a `clk` edge with `arst`=1, AR=0, Flags=4'b0000, `ill_op`=0.
  - Reset takes priority over a simultaneous `Exec`.
  - A reset between instructions discards no pending work, because every operation completes in the `Exec` cycle.
- Latency: results are visible on AR/Flags the cycle after the `Exec` cycle (one-edge latency). `ill_op` asserts in that same cycle and clears the next.
- Back-to-back `Exec` in consecutive cycles is legal. The second operation uses the AR and C values produced by the first.
- Flags are stable for at least the 3 cycles between `Exec` pulses that the instruction-cycle FSM guarantees, so a following `` `JZ ``/`` `JC ``/`` `JN ``/`` `JV `` sees them.
- No combinational path from inputs to outputs.

## Test plan
- Reset mid-stream: AR=8'h5A, then `arst` pulses while `Exec`=1 with add -> AR=0, Flags=0, `ill_op`=0 the next cycle.
- Add with carry chain:
  - Step 1: LOAD_I 8'hFF, then add-immediate 8'h01 -> AR=8'h00; Z=1, C=1, N=0, OV=0.
  - Step 2: addc-immediate 8'h00 -> AR=8'h01, C=0, Z=0.
- Signed overflow:
  - AR=8'h7F, add 8'h01 -> AR=8'h80, OV=1, N=1, C=0.
  - AR=8'h80, sub 8'h01 -> AR=8'h7F, OV=1, C=0.
  - AR=8'h00, sub 8'h01 -> AR=8'hFF, C=1, N=1.
- Logic and operand select: AR=8'hF0, `MBR`=8'h3C, `IBR`=8'hFF:
  - xor-memory -> 8'hCC with C preserved.
  - xnor-immediate of 8'hCC -> 8'hCC.
  - nand-immediate 8'hFF on AR=8'hFF -> 8'h00, Z=1, OV=0.
- No-effect and illegal opcodes: after any state, `` `STORE_X `` and `` `JZ `` with `Exec` leave AR/Flags bit-identical, `ill_op`=0. Opcode 8'hFF (undefined) -> AR/Flags unchanged, `ill_op` high exactly one cycle.
- `Exec` gating: inputs toggle randomly for 20 cycles with `Exec`=0 -> AR/Flags constant. Two consecutive `Exec` add-immediate 8'h01 from AR=0 -> AR=1 then 2.
